// File: rtl/afifo_core_pkg.sv
// Shared defaults for the afifo_core buffer and its RAM store.
// The optional sticky error flags are enabled with the AFIFO_FLAGS_EN macro.
package afifo_core_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 10;

endpackage

// File: rtl/afifo_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// The read register clears on rst; the array itself is never cleared.
module afifo_ram
    import afifo_core_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/afifo_core.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Defining AFIFO_FLAGS_EN adds sticky overflow/underflow outputs.
module afifo_core
    import afifo_core_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rd_en,
    output logic                  empty
`ifdef AFIFO_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    // The extra MSB is the wrap bit that distinguishes full from empty.
    function automatic logic ptrs_full(input logic [ADDRESS_WIDTH:0] w,
                                       input logic [ADDRESS_WIDTH:0] r);
        return (w[ADDRESS_WIDTH-1:0] == r[ADDRESS_WIDTH-1:0]) &&
               (w[ADDRESS_WIDTH] != r[ADDRESS_WIDTH]);
    endfunction

    function automatic logic ptrs_empty(input logic [ADDRESS_WIDTH:0] w,
                                        input logic [ADDRESS_WIDTH:0] r);
        return (w == r);
    endfunction

    logic [ADDRESS_WIDTH:0] wptr;
    logic [ADDRESS_WIDTH:0] rptr;
    logic [ADDRESS_WIDTH:0] wptr_next;
    logic [ADDRESS_WIDTH:0] rptr_next;
    logic                   wr_accept;
    logic                   rd_accept;

    // Acceptance uses the flags as they stood before the edge; rst wins.
    always_comb begin
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (rst) begin
            wr_accept = 1'b0;
            rd_accept = 1'b0;
        end else begin
            wr_accept = wr_en & ~full;
            rd_accept = rd_en & ~empty;
        end
    end

    // Next-pointer computation, wrapping naturally modulo 2**(ADDRESS_WIDTH+1).
    always_comb begin
        wptr_next = wptr;
        rptr_next = rptr;
        if (wr_accept) begin
            wptr_next = wptr + PTR_ONE;
        end else begin
            wptr_next = wptr;
        end
        if (rd_accept) begin
            rptr_next = rptr + PTR_ONE;
        end else begin
            rptr_next = rptr;
        end
    end

    // Pointer registers and flags; flags track the registered pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            empty <= ptrs_empty(wptr_next, rptr_next);
            full  <= ptrs_full(wptr_next, rptr_next);
        end
    end

`ifdef AFIFO_FLAGS_EN
    // Sticky error flags, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

    afifo_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_accept),
        .waddr(wptr[ADDRESS_WIDTH-1:0]),
        .wdata(data_in),
        .re   (rd_accept),
        .raddr(rptr[ADDRESS_WIDTH-1:0]),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_afifo_core.sv
// Directed bench for afifo_core (DATA_WIDTH=9, ADDRESS_WIDTH=3) with a queue model.
// Build with AFIFO_FLAGS_EN defined to also check the sticky flags.
module tb_afifo_core;

    localparam int DW    = 9;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic          full;
    logic          empty;
    logic [DW-1:0] data_out;
`ifdef AFIFO_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks   = 0;
    int failures = 0;

    afifo_core #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .wr_en   (wr_en),
        .full    (full),
        .data_out(data_out),
        .rd_en   (rd_en),
        .empty   (empty)
`ifdef AFIFO_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of held words plus the last word read out.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    bit            m_valid = 1'b0;
    bit            m_ovf;
    bit            m_unf;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_dout  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit can_wr;
            bit can_rd;
            can_wr = wr_en && (q.size() < DEPTH);
            can_rd = rd_en && (q.size() > 0);
            if (wr_en && q.size() == DEPTH) m_ovf = 1'b1;
            if (rd_en && q.size() == 0)     m_unf = 1'b1;
            if (can_rd) m_dout = q.pop_front();
            if (can_wr) q.push_back(data_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("data_out", 32'(data_out), 32'(m_dout));
`ifdef AFIFO_FLAGS_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
`endif
        end
    end

    // Drive one cycle of inputs at the falling edge.
    task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        data_in = d;
        rd_en   = rd;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        step(1'b1, 1'b0, 9'h000, 1'b0);
        step(1'b1, 1'b0, 9'h000, 1'b0);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_dout", 32'(data_out), 32'd0);

        // Fill: 0x101..0x108.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 9'(9'h101 + i), 1'b0);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Write while full must be dropped.
        step(1'b0, 1'b1, 9'h1FF, 1'b0);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
`ifdef AFIFO_FLAGS_EN
        chk("ovf_flag_set", 32'(overflow), 32'd1);
`endif

        // Drain in order, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 9'h000, 1'b1);
            step(1'b0, 1'b0, 9'h000, 1'b0);
            chk("drain_order", 32'(data_out), 32'(9'h101 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Read while empty leaves data_out alone.
        step(1'b0, 1'b0, 9'h000, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("unf_hold", 32'(data_out), 32'h108);
`ifdef AFIFO_FLAGS_EN
        chk("unf_flag_set", 32'(underflow), 32'd1);
        chk("ovf_flag_sticky", 32'(overflow), 32'd1);
`endif

        // Half occupancy with simultaneous read/write.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 9'(9'h010 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 9'(9'h020 + i), 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("simul_dout", 32'(data_out), 32'h025);
        chk("simul_full", 32'(full), 32'd0);
        chk("simul_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("simul_last", 32'(data_out), 32'h029);

        // Wrap-around with interleaved pairs.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 9'(9'h040 + i), 1'b0);
            step(1'b0, 1'b0, 9'h000, 1'b1);
            step(1'b0, 1'b0, 9'h000, 1'b0);
            chk("wrap_order", 32'(data_out), 32'(9'h040 + i));
        end

        // Write into empty with simultaneous read: no bypass.
        step(1'b0, 1'b1, 9'h0CC, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("no_bypass", 32'(data_out), 32'h053);

        // Mid-operation reset with entries held.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 9'(9'h060 + i), 1'b0);
        step(1'b1, 1'b1, 9'h0EE, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_dout", 32'(data_out), 32'd0);
`ifdef AFIFO_FLAGS_EN
        chk("rst_clr_ovf", 32'(overflow), 32'd0);
        chk("rst_clr_unf", 32'(underflow), 32'd0);
`endif
        step(1'b0, 1'b1, 9'h0AA, 1'b0);
        step(1'b0, 1'b0, 9'h000, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("post_rst_word", 32'(data_out), 32'h0AA);
        chk("post_rst_empty", 32'(empty), 32'd1);

        // Full-then-simultaneous read/write: read accepted, write dropped.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 9'(9'h080 + i), 1'b0);
        step(1'b0, 1'b1, 9'h0FF, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("full_rw_dout", 32'(data_out), 32'h080);
        chk("full_rw_full", 32'(full), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 9'h000, 1'b1);
        step(1'b0, 1'b0, 9'h000, 1'b0);
        chk("full_rw_last", 32'(data_out), 32'h087);
        chk("full_rw_empty", 32'(empty), 32'd1);

        step(1'b0, 1'b0, 9'h000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
